// File: rtl/aes_sbox_sched.sv
// Two-requester scheduler for a single pipelined AES S-box: serialises state (16 B)
// and key-schedule (4 B) jobs byte by byte. SBOX_SCHED_RR_EN selects round-robin ties.
module aes_sbox_sched #(
    parameter int SBOX_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_req,
    input  logic [127:0] st_data,
    output logic         st_ack,
    output logic         st_done,
    output logic [127:0] st_result,
    input  logic         ks_req,
    input  logic [31:0]  ks_word,
    output logic         ks_ack,
    output logic         ks_done,
    output logic [31:0]  ks_result,
    output logic [7:0]   sbox_in,
    input  logic [7:0]   sbox_out,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic       vld;
        logic [3:0] idx;
    } tag_t;

    state_t                 state_q, state_d;
    logic [127:0]           cap_q, cap_d;
    logic                   job_ks_q, job_ks_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [1:0]             drain_q, drain_d;
    tag_t [SBOX_LAT-1:0]    tag_q, tag_d;
    logic                   st_ack_q, st_ack_d;
    logic                   ks_ack_q, ks_ack_d;
    logic                   st_done_q, st_done_d;
    logic                   ks_done_q, ks_done_d;
    logic                   busy_q, busy_d;
    logic [7:0]             sbox_in_q, sbox_in_d;
    logic [127:0]           st_res_q, st_res_d;
    logic [31:0]            ks_res_q, ks_res_d;
`ifdef SBOX_SCHED_RR_EN
    logic                   last_ks_q, last_ks_d;
`endif

    logic       grant_ks;
    logic [3:0] last_idx;
    logic [3:0] cnt_inc;
    tag_t       wb_tag;

    // Tie-break: round robin against the previous owner, or ks always wins.
`ifdef SBOX_SCHED_RR_EN
    assign grant_ks = ks_req & (~st_req | ~last_ks_q);
`else
    assign grant_ks = ks_req;
`endif

    assign last_idx = job_ks_q ? 4'd3 : 4'd15;
    assign cnt_inc  = cnt_q + 4'd1;
    assign wb_tag   = tag_q[SBOX_LAT-1];

    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        job_ks_d  = job_ks_q;
        cnt_d     = cnt_q;
        drain_d   = drain_q;
        st_ack_d  = 1'b0;
        ks_ack_d  = 1'b0;
        st_done_d = 1'b0;
        ks_done_d = 1'b0;
        sbox_in_d = 8'h00;
        st_res_d  = st_res_q;
        ks_res_d  = ks_res_q;
`ifdef SBOX_SCHED_RR_EN
        last_ks_d = last_ks_q;
`endif

        tag_d[0] = '0;
        for (int i = 1; i < SBOX_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        // Tag at the S-box output names the byte slot sbox_out belongs to.
        if (wb_tag.vld) begin
            if (job_ks_q) ks_res_d[{wb_tag.idx[1:0], 3'b000} +: 8] = sbox_out;
            else          st_res_d[{wb_tag.idx, 3'b000} +: 8]      = sbox_out;
        end

        case (state_q)
            IDLE: begin
                if (st_req || ks_req) begin
                    state_d   = ISSUE;
                    job_ks_d  = grant_ks;
                    cnt_d     = 4'd0;
                    cap_d     = grant_ks ? {96'h0, ks_word} : st_data;
                    sbox_in_d = grant_ks ? ks_word[7:0] : st_data[7:0];
                    ks_ack_d  = grant_ks;
                    st_ack_d  = ~grant_ks;
`ifdef SBOX_SCHED_RR_EN
                    last_ks_d = grant_ks;
`endif
                end
            end
            ISSUE: begin
                tag_d[0] = '{vld: 1'b1, idx: cnt_q};
                if (cnt_q == last_idx) begin
                    state_d = DRAIN;
                    drain_d = 2'd0;
                end else begin
                    cnt_d     = cnt_inc;
                    sbox_in_d = cap_q[{cnt_inc, 3'b000} +: 8];
                end
            end
            DRAIN: begin
                if (drain_q == 2'(SBOX_LAT - 1)) begin
                    state_d   = DONE;
                    ks_done_d = job_ks_q;
                    st_done_d = ~job_ks_q;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cap_q     <= '0;
            job_ks_q  <= 1'b0;
            cnt_q     <= '0;
            drain_q   <= '0;
            tag_q     <= '0;
            st_ack_q  <= 1'b0;
            ks_ack_q  <= 1'b0;
            st_done_q <= 1'b0;
            ks_done_q <= 1'b0;
            busy_q    <= 1'b0;
            sbox_in_q <= '0;
            st_res_q  <= '0;
            ks_res_q  <= '0;
`ifdef SBOX_SCHED_RR_EN
            last_ks_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            job_ks_q  <= job_ks_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            tag_q     <= tag_d;
            st_ack_q  <= st_ack_d;
            ks_ack_q  <= ks_ack_d;
            st_done_q <= st_done_d;
            ks_done_q <= ks_done_d;
            busy_q    <= busy_d;
            sbox_in_q <= sbox_in_d;
            st_res_q  <= st_res_d;
            ks_res_q  <= ks_res_d;
`ifdef SBOX_SCHED_RR_EN
            last_ks_q <= last_ks_d;
`endif
        end
    end

    assign st_ack    = st_ack_q;
    assign ks_ack    = ks_ack_q;
    assign st_done   = st_done_q;
    assign ks_done   = ks_done_q;
    assign st_result = st_res_q;
    assign ks_result = ks_res_q;
    assign sbox_in   = sbox_in_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Bench for aes_sbox_sched: AES S-box model on the shared port, scoreboard of done results.
module tb_aes_sbox_sched;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         st_req = 1'b0, ks_req = 1'b0;
    logic [127:0] st_data = '0;
    logic [31:0]  ks_word = '0;
    logic         st_ack, st_done, ks_ack, ks_done, busy;
    logic [127:0] st_result;
    logic [31:0]  ks_result;
    logic [7:0]   sbox_in;
    logic [7:0]   sbox_out = 8'h00;

    always #5 clk = ~clk;

    aes_sbox_sched #(.SBOX_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_req(st_req), .st_data(st_data), .st_ack(st_ack), .st_done(st_done), .st_result(st_result),
        .ks_req(ks_req), .ks_word(ks_word), .ks_ack(ks_ack), .ks_done(ks_done), .ks_result(ks_result),
        .sbox_in(sbox_in), .sbox_out(sbox_out), .busy(busy)
    );

    typedef struct {
        bit           kind;
        logic [127:0] res;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0, errors = 0, cyc = 0;
    logic [7:0]   sb_tbl [256];
    logic [7:0]   sh [0:LAT];
    logic [127:0] st_model = '0;
    logic [31:0]  ks_model = '0;
    bit           m_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00; aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse in GF(2^8) by search, then the AES affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv, r, acc;
        inv = 8'h00;
        if (x != 8'h00)
            for (int j = 1; j < 256; j++)
                if (gmul(x, 8'(j)) == 8'h01) inv = 8'(j);
        acc = inv; r = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            acc = acc ^ r;
        end
        return acc ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] d, input int n);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = sb_tbl[d[8*i +: 8]];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0: return st_ack | ks_ack;
            1: return st_done;
            2: return ks_done;
            default: return !busy;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            hit = cond(sel);
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL timeout_%s actual=none expected=event", nm);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_acks"},  {st_ack, ks_ack}, 2'b00);
        chk({nm, "_dones"}, {st_done, ks_done}, 2'b00);
        chk({nm, "_busy"},  busy, 1'b0);
        chk({nm, "_sbox"},  sbox_in, 8'h00);
        chk({nm, "_stres"}, st_result, '0);
        chk({nm, "_ksres"}, ks_result, '0);
    endtask

    // Single job into an idle scheduler; checks ack timing and the byte stream.
    task automatic run_job(input bit kind, input logic [127:0] d, input logic [127:0] exp);
        int n, c0;
        logic [127:0] dd;
        n  = kind ? 4 : 16;
        c0 = cyc;
        dd = kind ? {96'h0, d[31:0]} : d;
        if (kind) begin ks_word = d[31:0]; ks_req = 1'b1; end
        else      begin st_data = d;       st_req = 1'b1; end
        wait_for(0, "ack");
        chk("ack_cyc", cyc, c0 + 1);
        chk("ack_kind", {ks_ack, st_ack}, {kind, ~kind});
        st_req = 1'b0; ks_req = 1'b0;
        sb.push_back('{kind: kind, res: exp, cyc: cyc + n + LAT});
        m_last = kind;
        for (int k = 0; k < n; k++) begin
            chk("sbox_in_byte", sbox_in, dd[8*k +: 8]);
            @(negedge clk);
        end
        chk("sbox_in_drain", sbox_in, 8'h00);
        wait_for(3, "idle");
    endtask

    // S-box model: sbox_in driven in cycle C is presented on sbox_out during C+LAT.
    initial begin
        for (int i = 0; i <= LAT; i++) sh[i] = 8'h00;
        forever begin
            @(negedge clk);
            for (int i = LAT; i > 0; i--) sh[i] = sh[i-1];
            sh[0] = sbox_in;
            sbox_out = sb_tbl[sh[LAT]];
        end
    end

    // Monitor: every done pulse must match the oldest outstanding job.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (st_done || ks_done)) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected actual=%b%b expected=none", st_done, ks_done);
                end else begin
                    e = sb.pop_front();
                    chk("done_kind", {ks_done, st_done}, {e.kind, ~e.kind});
                    chk("done_cyc", cyc, e.cyc);
                    if (e.kind) begin
                        ks_model = e.res[31:0];
                        chk("ks_result", ks_result, ks_model);
                        chk("st_result_kept", st_result, st_model);
                    end else begin
                        st_model = e.res;
                        chk("st_result", st_result, st_model);
                        chk("ks_result_kept", ks_result, ks_model);
                    end
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        errors++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [127:0] d, dk;
        bit kind, want, got;
        int cnt;
        for (int x = 0; x < 256; x++) sb_tbl[x] = sbox_calc(8'(x));

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        run_job(1'b1, 128'h01020304, 128'h7c777bf2);
        run_job(1'b0, 128'h0, {16{8'h63}});
        run_job(1'b0, 128'h53, {{15{8'h63}}, 8'hed});

        // Reset while byte 8 of a state job is in flight.
        d = {$urandom, $urandom, $urandom, $urandom};
        st_data = d; st_req = 1'b1;
        wait_for(0, "rst_ack");
        st_req = 1'b0;
        repeat (8) @(negedge clk);
        chk("midjob_byte8", sbox_in, d[71:64]);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_zero("midjob_rst");
        st_model = '0; ks_model = '0; m_last = 1'b0;
        cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (st_done) cnt++;
        end
        chk("midjob_no_done", cnt, 0);
        d = {$urandom, $urandom, $urandom, $urandom};
        run_job(1'b0, d, sub_bytes(d, 16));

        // Ties: both pending, the winner re-requests after its done.
        d  = {$urandom, $urandom, $urandom, $urandom};
        dk = {96'h0, $urandom};
        st_data = d; ks_word = dk[31:0];
        st_req = 1'b1; ks_req = 1'b1;
        for (int g = 0; g < 3; g++) begin
`ifdef SBOX_SCHED_RR_EN
            want = ~m_last;
`else
            want = 1'b1;
`endif
            wait_for(0, "tie_ack");
            chk("tie_one_ack", st_ack & ks_ack, 1'b0);
            got = ks_ack;
            chk("tie_grant", got, want);
            m_last = got;
            if (got) ks_req = 1'b0; else st_req = 1'b0;
            sb.push_back('{kind: got, res: got ? sub_bytes(dk, 4) : sub_bytes(d, 16),
                           cyc: cyc + (got ? 4 : 16) + LAT});
            if (g == 2) begin st_req = 1'b0; ks_req = 1'b0; end
            wait_for(got ? 2 : 1, "tie_done");
            if (g < 2) begin
                if (got) ks_req = 1'b1; else st_req = 1'b1;
            end
        end
        wait_for(3, "tie_idle");

        // Request held through done: one idle cycle, then a second ack.
        dk = {96'h0, $urandom};
        ks_word = dk[31:0]; ks_req = 1'b1;
        wait_for(0, "hold_ack");
        sb.push_back('{kind: 1'b1, res: sub_bytes(dk, 4), cyc: cyc + 4 + LAT});
        wait_for(2, "hold_done");
        @(negedge clk);
        chk("hold_gap_busy", busy, 1'b0);
        chk("hold_gap_ack", ks_ack, 1'b0);
        @(negedge clk);
        chk("hold_second_ack", ks_ack, 1'b1);
        chk("hold_busy_back", busy, 1'b1);
        ks_req = 1'b0;
        sb.push_back('{kind: 1'b1, res: sub_bytes(dk, 4), cyc: cyc + 4 + LAT});
        m_last = 1'b1;
        wait_for(3, "hold_idle");

        repeat (12) begin
            kind = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_job(kind, d, sub_bytes(d, kind ? 4 : 16));
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
